// File: rtl/llsc_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : llsc_monitor_pkg
// Purpose  : Shared defaults and encodings for the LL/SC reservation monitor.
//            The optional feature macro is LLSC_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
package llsc_monitor_pkg;

    localparam int c_DEF_NCTX      = 4;
    localparam int c_DEF_ADDR_W    = 32;
    localparam int c_DEF_GRAN_LOG2 = 2;
    localparam int c_DEF_TIMEOUT   = 255;

    localparam logic c_SC_SUCCESS = 1'b1;
    localparam logic c_SC_FAIL    = 1'b0;

    // Context index width; a single context still needs a one-bit index
    function automatic int ctx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/llsc_entry.sv
`default_nettype none
// ============================================================================
// Module   : llsc_entry
// Purpose  : One reservation context: valid bit, granule address register,
//            optional lifetime counter (LLSC_TIMEOUT_EN) and granule matches.
// Revision : 1.0 - initial release
// ============================================================================
module llsc_entry
    import llsc_monitor_pkg::*;
#(
    parameter int ADDR_W    = c_DEF_ADDR_W,
    parameter int GRAN_LOG2 = c_DEF_GRAN_LOG2,
    parameter int TIMEOUT   = c_DEF_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        set,
    input  logic [ADDR_W-GRAN_LOG2-1:0] set_gran,
    input  logic                        clr,
    input  logic [ADDR_W-GRAN_LOG2-1:0] sc_gran,
    input  logic [ADDR_W-GRAN_LOG2-1:0] st_gran,
    output logic                        valid,
    output logic                        sc_hit,
    output logic                        st_hit
);

    logic                        r_valid;
    logic [ADDR_W-GRAN_LOG2-1:0] r_gran;

`ifdef LLSC_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    logic [c_CNT_W-1:0] r_cnt;

    // Lifetime counter: reload on LL, count down while the reservation lives
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_cnt <= '0;
        end else if (set) begin
            r_cnt <= c_CNT_W'(TIMEOUT);
        end else if (clr) begin
            r_cnt <= '0;
        end else if (r_valid && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end
`else
    localparam int c_unused_timeout = TIMEOUT;
`endif

    // Reservation state; priority rst > flush > LL set > clear (> expiry)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_gran  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (set) begin
            r_valid <= 1'b1;
            r_gran  <= set_gran;
        end else if (clr) begin
            r_valid <= 1'b0;
        end
`ifdef LLSC_TIMEOUT_EN
        else if (r_valid && (r_cnt == c_CNT_W'(1))) begin
            r_valid <= 1'b0;
        end
`endif
    end

    assign valid  = r_valid;
    assign sc_hit = r_valid && (r_gran == sc_gran);
    assign st_hit = r_valid && (r_gran == st_gran);

endmodule
`default_nettype wire

// File: rtl/llsc_monitor.sv
`default_nettype none
// ============================================================================
// Module   : llsc_monitor
// Purpose  : Load-linked / store-conditional reservation monitor for NCTX
//            hardware contexts with a one-cycle registered SC result.
//            Optional reservation lifetime: define LLSC_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module llsc_monitor
    import llsc_monitor_pkg::*;
#(
    parameter int NCTX      = c_DEF_NCTX,
    parameter int ADDR_W    = c_DEF_ADDR_W,
    parameter int GRAN_LOG2 = c_DEF_GRAN_LOG2,
    parameter int TIMEOUT   = c_DEF_TIMEOUT,
    localparam int CTX_W    = ctx_width(NCTX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCTX-1:0]   flush,
    input  logic              ll_valid,
    input  logic [CTX_W-1:0]  ll_ctx,
    input  logic [ADDR_W-1:0] ll_addr,
    input  logic              sc_valid,
    input  logic [CTX_W-1:0]  sc_ctx,
    input  logic [ADDR_W-1:0] sc_addr,
    input  logic              st_valid,
    input  logic [CTX_W-1:0]  st_ctx,
    input  logic [ADDR_W-1:0] st_addr,
    output logic              sc_done,
    output logic              sc_success,
    output logic [CTX_W-1:0]  sc_done_ctx,
    output logic [NCTX-1:0]   llbit_o
);

    logic [NCTX-1:0]  w_valid;
    logic [NCTX-1:0]  w_sc_hit;
    logic [NCTX-1:0]  w_st_hit;
    logic [NCTX-1:0]  w_set;
    logic [NCTX-1:0]  w_clr;
    logic             w_sc_in_range;
    logic             w_st_in_range;
    logic             w_sc_own_hit;
    logic             w_sc_own_flush;
    logic             w_sc_ok;

    logic             r_sc_done;
    logic             r_sc_success;
    logic [CTX_W-1:0] r_sc_done_ctx;

    // SC verdict from pre-edge state and per-context set/clear requests
    always_comb begin
        w_sc_in_range  = (int'(sc_ctx) < NCTX);
        w_st_in_range  = (int'(st_ctx) < NCTX);
        w_sc_own_hit   = 1'b0;
        w_sc_own_flush = 1'b0;
        for (int i = 0; i < NCTX; i++) begin
            if (sc_ctx == CTX_W'(i)) begin
                w_sc_own_hit   = w_sc_hit[i];
                w_sc_own_flush = flush[i];
            end
        end
        // A flushed SC fails and must not disturb other reservations
        w_sc_ok = sc_valid && w_sc_in_range && !w_sc_own_flush && w_sc_own_hit;
        w_set   = '0;
        w_clr   = '0;
        for (int i = 0; i < NCTX; i++) begin
            w_set[i] = ll_valid && (ll_ctx == CTX_W'(i));
            w_clr[i] = (sc_valid && (sc_ctx == CTX_W'(i)))
                    || (w_sc_ok && (sc_ctx != CTX_W'(i)) && w_sc_hit[i])
                    || (st_valid && w_st_in_range && (st_ctx != CTX_W'(i)) && w_st_hit[i]);
        end
    end

    // Registered SC report, valid the cycle after the request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sc_done     <= 1'b0;
            r_sc_success  <= c_SC_FAIL;
            r_sc_done_ctx <= '0;
        end else begin
            r_sc_done    <= sc_valid;
            r_sc_success <= w_sc_ok ? c_SC_SUCCESS : c_SC_FAIL;
            if (sc_valid) begin
                r_sc_done_ctx <= sc_ctx;
            end
        end
    end

    for (genvar i = 0; i < NCTX; i++) begin : g_entry
        llsc_entry #(
            .ADDR_W    (ADDR_W),
            .GRAN_LOG2 (GRAN_LOG2),
            .TIMEOUT   (TIMEOUT)
        ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush[i]),
            .set      (w_set[i]),
            .set_gran (ll_addr[ADDR_W-1:GRAN_LOG2]),
            .clr      (w_clr[i]),
            .sc_gran  (sc_addr[ADDR_W-1:GRAN_LOG2]),
            .st_gran  (st_addr[ADDR_W-1:GRAN_LOG2]),
            .valid    (w_valid[i]),
            .sc_hit   (w_sc_hit[i]),
            .st_hit   (w_st_hit[i])
        );
    end

    // Byte offsets inside a granule never take part in matching
    if (GRAN_LOG2 > 0) begin : g_unused_offset
        logic w_unused_offset;
        assign w_unused_offset = ^{ll_addr[GRAN_LOG2-1:0], sc_addr[GRAN_LOG2-1:0],
                                   st_addr[GRAN_LOG2-1:0]};
    end

    assign sc_done     = r_sc_done;
    assign sc_success  = r_sc_success;
    assign sc_done_ctx = r_sc_done_ctx;
    assign llbit_o     = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_llsc_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_llsc_monitor
// Purpose  : Self-checking bench for llsc_monitor: directed scenarios plus
//            randomized traffic against a behavioural reservation model.
//            Define LLSC_TIMEOUT_EN to exercise the lifetime counter (TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_llsc_monitor;

    localparam int NCTX      = 4;
    localparam int ADDR_W    = 32;
    localparam int GRAN_LOG2 = 2;
`ifdef LLSC_TIMEOUT_EN
    localparam int TIMEOUT   = 4;
`else
    localparam int TIMEOUT   = 255;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NCTX-1:0]   flush;
    logic              ll_valid, sc_valid, st_valid;
    logic [1:0]        ll_ctx, sc_ctx, st_ctx;
    logic [ADDR_W-1:0] ll_addr, sc_addr, st_addr;
    logic              sc_done, sc_success;
    logic [1:0]        sc_done_ctx;
    logic [NCTX-1:0]   llbit_o;

    int total = 0;
    int bad   = 0;

    // Behavioural model: one reservation per context, compared by granule
    logic              m_valid [NCTX];
    logic [ADDR_W-1:0] m_addr  [NCTX];
    int                m_cnt   [NCTX];
    logic              e_done, e_succ;
    logic [1:0]        e_ctx;

    llsc_monitor #(
        .NCTX(NCTX), .ADDR_W(ADDR_W), .GRAN_LOG2(GRAN_LOG2), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ll_valid(ll_valid), .ll_ctx(ll_ctx), .ll_addr(ll_addr),
        .sc_valid(sc_valid), .sc_ctx(sc_ctx), .sc_addr(sc_addr),
        .st_valid(st_valid), .st_ctx(st_ctx), .st_addr(st_addr),
        .sc_done(sc_done), .sc_success(sc_success), .sc_done_ctx(sc_done_ctx),
        .llbit_o(llbit_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic same_gran(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return (a / (1 << GRAN_LOG2)) == (b / (1 << GRAN_LOG2));
    endfunction

    function automatic logic [NCTX-1:0] m_llbits();
        logic [NCTX-1:0] v;
        for (int i = 0; i < NCTX; i++) v[i] = m_valid[i];
        return v;
    endfunction

    // Apply one clock edge's worth of rules to the model from the current inputs
    task automatic model_edge();
        logic succ, kill;
        if (rst) begin
            for (int i = 0; i < NCTX; i++) begin
                m_valid[i] = 1'b0; m_addr[i] = '0; m_cnt[i] = 0;
            end
            e_done = 1'b0; e_succ = 1'b0; e_ctx = 2'd0;
            return;
        end
        succ = sc_valid && (int'(sc_ctx) < NCTX) && !flush[sc_ctx]
            && m_valid[sc_ctx] && same_gran(m_addr[sc_ctx], sc_addr);
        for (int i = 0; i < NCTX; i++) begin
            kill = (sc_valid && int'(sc_ctx) == i)
                || (succ && int'(sc_ctx) != i && m_valid[i] && same_gran(m_addr[i], sc_addr))
                || (st_valid && int'(st_ctx) != i && m_valid[i] && same_gran(m_addr[i], st_addr));
            if (flush[i]) begin
                m_valid[i] = 1'b0; m_cnt[i] = 0;
            end else if (ll_valid && int'(ll_ctx) == i) begin
                m_valid[i] = 1'b1; m_addr[i] = ll_addr; m_cnt[i] = TIMEOUT;
            end else if (kill) begin
                m_valid[i] = 1'b0; m_cnt[i] = 0;
            end else if (m_valid[i]) begin
`ifdef LLSC_TIMEOUT_EN
                m_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 0) m_valid[i] = 1'b0;
`endif
            end
        end
        e_done = sc_valid;
        e_succ = succ;
        if (sc_valid) e_ctx = sc_ctx;
    endtask

    task automatic set_idle();
        rst = 1'b0; flush = '0;
        ll_valid = 1'b0; ll_ctx = '0; ll_addr = '0;
        sc_valid = 1'b0; sc_ctx = '0; sc_addr = '0;
        st_valid = 1'b0; st_ctx = '0; st_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        set_idle();
    endtask

    task automatic do_ll(input logic [1:0] c, input logic [ADDR_W-1:0] a);
        ll_valid = 1'b1; ll_ctx = c; ll_addr = a;
    endtask

    task automatic do_sc(input logic [1:0] c, input logic [ADDR_W-1:0] a);
        sc_valid = 1'b1; sc_ctx = c; sc_addr = a;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1; tick();
        rst = 1'b1; tick();
        total++;
        if (llbit_o !== 4'b0000 || sc_done !== 1'b0 || sc_success !== 1'b0 || sc_done_ctx !== 2'd0) begin
            bad++;
            $display("FAIL reset: llbit=%b done=%b succ=%b ctx=%0d, want 0000/0/0/0",
                     llbit_o, sc_done, sc_success, sc_done_ctx);
        end
    endtask

    task automatic test_sc_basic();
        do_ll(2'd0, 32'h100); tick();
        total++;
        if (llbit_o[0] !== 1'b1) begin bad++; $display("FAIL ll_set: llbit0=%b want 1", llbit_o[0]); end
        do_sc(2'd0, 32'h100);
        total++;
        if (sc_done !== 1'b0) begin bad++; $display("FAIL sc_latency: done=%b want 0 before edge", sc_done); end
        tick();
        total++;
        if (sc_done !== 1'b1 || sc_success !== 1'b1 || sc_done_ctx !== 2'd0 || llbit_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL sc_basic: done=%b succ=%b ctx=%0d llbit0=%b, want 1/1/0/0",
                     sc_done, sc_success, sc_done_ctx, llbit_o[0]);
        end
        tick();
        total++;
        if (sc_done !== 1'b0) begin bad++; $display("FAIL sc_pulse: done=%b want 0", sc_done); end
    endtask

    task automatic test_store_kill();
        do_ll(2'd1, 32'h200); tick();
        st_valid = 1'b1; st_ctx = 2'd2; st_addr = 32'h202; tick();
        total++;
        if (llbit_o[1] !== 1'b0) begin bad++; $display("FAIL store_clear: llbit1=%b want 0", llbit_o[1]); end
        do_sc(2'd1, 32'h200); tick();
        total++;
        if (sc_done !== 1'b1 || sc_success !== 1'b0 || sc_done_ctx !== 2'd1) begin
            bad++;
            $display("FAIL store_kill: done=%b succ=%b ctx=%0d, want 1/0/1", sc_done, sc_success, sc_done_ctx);
        end
        // A store from the owning context leaves its own reservation alone
        do_ll(2'd2, 32'h208); tick();
        st_valid = 1'b1; st_ctx = 2'd2; st_addr = 32'h209; tick();
        total++;
        if (llbit_o[2] !== 1'b1) begin bad++; $display("FAIL store_own: llbit2=%b want 1", llbit_o[2]); end
        rst = 1'b1; tick();
    endtask

    task automatic test_sc_kills_others();
        do_ll(2'd0, 32'h300); tick();
        do_ll(2'd1, 32'h300); tick();
        do_ll(2'd2, 32'h310); tick();
        do_sc(2'd0, 32'h301); tick();
        total++;
        if (sc_success !== 1'b1 || llbit_o !== 4'b0100) begin
            bad++;
            $display("FAIL sc_kill_others: succ=%b llbit=%b, want 1/0100", sc_success, llbit_o);
        end
        do_sc(2'd1, 32'h300); tick();
        total++;
        if (sc_done !== 1'b1 || sc_success !== 1'b0) begin
            bad++;
            $display("FAIL sc_after_kill: done=%b succ=%b, want 1/0", sc_done, sc_success);
        end
        rst = 1'b1; tick();
    endtask

    task automatic test_flush();
        do_ll(2'd3, 32'h40); flush = 4'b1000; tick();
        total++;
        if (llbit_o[3] !== 1'b0) begin bad++; $display("FAIL flush_vs_ll: llbit3=%b want 0", llbit_o[3]); end
        do_ll(2'd3, 32'h40); tick();
        do_ll(2'd2, 32'h40); tick();
        do_sc(2'd3, 32'h40); flush = 4'b1000; tick();
        total++;
        if (sc_done !== 1'b1 || sc_success !== 1'b0 || sc_done_ctx !== 2'd3 || llbit_o !== 4'b0100) begin
            bad++;
            $display("FAIL flush_sc: done=%b succ=%b ctx=%0d llbit=%b, want 1/0/3/0100",
                     sc_done, sc_success, sc_done_ctx, llbit_o);
        end
        rst = 1'b1; tick();
    endtask

    task automatic test_ll_sc_same_ctx();
        do_ll(2'd2, 32'h500); tick();
        do_ll(2'd2, 32'h600); do_sc(2'd2, 32'h500); tick();
        total++;
        if (sc_success !== 1'b1 || llbit_o[2] !== 1'b1) begin
            bad++;
            $display("FAIL ll_sc_same: succ=%b llbit2=%b, want 1/1", sc_success, llbit_o[2]);
        end
        do_sc(2'd2, 32'h603); tick();
        total++;
        if (sc_success !== 1'b1 || llbit_o[2] !== 1'b0) begin
            bad++;
            $display("FAIL ll_sc_new_addr: succ=%b llbit2=%b, want 1/0", sc_success, llbit_o[2]);
        end
    endtask

    task automatic test_rst_discard();
        do_ll(2'd0, 32'h100); tick();
        do_sc(2'd0, 32'h100); tick();
        rst = 1'b1; tick();
        total++;
        if (sc_done !== 1'b0 || llbit_o !== 4'b0000) begin
            bad++;
            $display("FAIL rst_after_sc: done=%b llbit=%b, want 0/0000", sc_done, llbit_o);
        end
        do_ll(2'd1, 32'h100); tick();
        do_sc(2'd1, 32'h100); do_ll(2'd2, 32'h100); rst = 1'b1; tick();
        total++;
        if (sc_done !== 1'b0 || llbit_o !== 4'b0000) begin
            bad++;
            $display("FAIL rst_with_req: done=%b llbit=%b, want 0/0000", sc_done, llbit_o);
        end
    endtask

`ifdef LLSC_TIMEOUT_EN
    task automatic test_timeout();
        rst = 1'b1; tick();
        do_ll(2'd0, 32'h700); tick();
        repeat (5) tick();
        do_sc(2'd0, 32'h700); tick();
        total++;
        if (sc_success !== 1'b0) begin bad++; $display("FAIL timeout_expire: succ=%b want 0", sc_success); end
        do_ll(2'd0, 32'h700); tick();
        repeat (2) tick();
        do_sc(2'd0, 32'h700); tick();
        total++;
        if (sc_success !== 1'b1) begin bad++; $display("FAIL timeout_alive: succ=%b want 1", sc_success); end
        do_ll(2'd1, 32'h700); tick();
        repeat (3) tick();
        do_ll(2'd1, 32'h704); tick();
        total++;
        if (llbit_o[1] !== 1'b1) begin bad++; $display("FAIL timeout_reload: llbit1=%b want 1", llbit_o[1]); end
        tick();
        total++;
        if (llbit_o[1] !== 1'b1) begin bad++; $display("FAIL timeout_reload_hold: llbit1=%b want 1", llbit_o[1]); end
    endtask
`endif

    task automatic test_random();
        logic [ADDR_W-1:0] pool [4];
        int errs;
        pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200; pool[3] = 32'h800;
        errs = 0;
        rst = 1'b1; tick();
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            flush    = '0;
            for (int i = 0; i < NCTX; i++) flush[i] = ($urandom_range(0, 19) == 0);
            ll_valid = ($urandom_range(0, 9) < 4);
            ll_ctx   = 2'($urandom_range(0, 3));
            ll_addr  = pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 5));
            sc_valid = ($urandom_range(0, 9) < 4);
            sc_ctx   = 2'($urandom_range(0, 3));
            sc_addr  = pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 5));
            st_valid = ($urandom_range(0, 9) < 3);
            st_ctx   = 2'($urandom_range(0, 3));
            st_addr  = pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 5));
            tick();
            total++;
            if (sc_done !== e_done || sc_success !== e_succ || sc_done_ctx !== e_ctx
                || llbit_o !== m_llbits()) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: done=%b succ=%b ctx=%0d llbit=%b, want %b/%b/%0d/%b",
                             n, sc_done, sc_success, sc_done_ctx, llbit_o,
                             e_done, e_succ, e_ctx, m_llbits());
            end
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_sc_basic();
        test_store_kill();
        test_sc_kills_others();
        test_flush();
        test_ll_sc_same_ctx();
        test_rst_discard();
`ifdef LLSC_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
